// File: rtl/stream_agg.sv
// Streaming group aggregator: SUM/MIN/MAX/COUNT per ilast-delimited group, one result per group.
// Build option: define AGG_SAT_EN for saturating SUM (default build wraps modulo 2^(`NUM+1)).
`timescale 1ns/1ps
`ifndef NUM
`define NUM 31
`endif

module stream_agg #(
    parameter int OPW = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [`NUM:0]   idata,
    input  logic                   ivalid,
    input  logic                   ilast,
    input  logic [OPW-1:0]         op,
    output logic                   istop,
    output logic signed [`NUM:0]   cdata,
    output logic                   cvalid,
    input  logic                   cstop
);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_e;

    localparam logic [OPW-1:0] OP_SUM = OPW'(0);
    localparam logic [OPW-1:0] OP_MIN = OPW'(1);
    localparam logic [OPW-1:0] OP_MAX = OPW'(2);

    localparam logic signed [`NUM:0] SMAX = {1'b0, {`NUM{1'b1}}};
    localparam logic signed [`NUM:0] ONE  = {{`NUM{1'b0}}, 1'b1};
`ifdef AGG_SAT_EN
    localparam logic signed [`NUM:0] SMIN = {1'b1, {`NUM{1'b0}}};
`endif

    state_e                  state_q, state_d;
    logic signed [`NUM:0]    acc_q, acc_d;
    logic signed [`NUM:0]    cdata_q, cdata_d;
    logic [OPW-1:0]          op_q, op_d;
    logic signed [`NUM:0]    sum_sel;
    logic signed [`NUM:0]    upd;
    logic                    accept;

`ifdef AGG_SAT_EN
    // One guard bit: overflow shows up as disagreement of the top two bits.
    logic [`NUM+1:0] sum_w;
    assign sum_w   = {acc_q[`NUM], acc_q} + {idata[`NUM], idata};
    assign sum_sel = (sum_w[`NUM+1] != sum_w[`NUM]) ? (sum_w[`NUM+1] ? SMIN : SMAX)
                                                    : sum_w[`NUM:0];
`else
    assign sum_sel = acc_q + idata;
`endif

    always_comb begin
        upd = acc_q;
        case (op_q)
            OP_SUM:  upd = sum_sel;
            OP_MIN:  upd = (idata < acc_q) ? idata : acc_q;
            OP_MAX:  upd = (idata > acc_q) ? idata : acc_q;
            default: upd = (acc_q == SMAX) ? acc_q : acc_q + ONE;
        endcase
    end

    assign accept = ivalid && (state_q != EMIT);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cdata_d = cdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = op;
                    acc_d   = (op == OPW'(3)) ? ONE : idata;
                    state_d = ilast ? EMIT : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = upd;
                    if (ilast) state_d = EMIT;
                end
            end
            EMIT: begin
                if (!cstop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Result register only moves on group close, so cdata keeps the last result otherwise.
        if (accept && ilast) cdata_d = acc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cdata_q <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cdata_q <= cdata_d;
            op_q    <= op_d;
        end
    end

    assign istop  = (state_q == EMIT);
    assign cvalid = (state_q == EMIT);
    assign cdata  = cdata_q;

endmodule

// File: doc/stream_agg.md
Name: stream_agg

Overview:
- Streaming group-aggregation core; sits directly upstream of the output buffer stage.
- Consumes a stream of signed column values delimited into groups by a last flag.
- Computes one of SUM / MIN / MAX / COUNT per group.
- Presents one result per group on the core-side cdata/cvalid/cstop interface that the output buffer loads.

Parameters:
- OPW, 2, width of op select.
- Data width is not a parameter: all data paths are signed [`NUM:0] from def.svh (`NUM+1 bits).

Ports:
- clk  input  1  sole clock, all state on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- idata  input  `NUM+1  signed input element.
- ivalid  input  1  idata/ilast/op valid this cycle.
- ilast  input  1  element is last of its group.
- op  input  OPW  0=SUM 1=MIN 2=MAX 3=COUNT; sampled on first element of a group.
- istop  output  1  upstream must hold; element not accepted.
- cdata  output  `NUM+1  signed group result to output buffer.
- cvalid  output  1  cdata holds a result.
- cstop  input  1  output buffer full and stalled; core must hold cdata/cvalid.

Behaviour:
- Reset (async assert, sync-to-clk deassert):
  - state=IDLE, cvalid=0, cdata=0, istop=0.
  - Accumulator, count and latched op cleared.
- Accept rule: element accepted on posedge when ivalid && !istop.
- istop = (state==EMIT); combinational from state only, no path from ivalid.
- States:
  - IDLE: nothing accumulated.
    - Accepted element: latch op; acc=idata for SUM/MIN/MAX, acc=1 for COUNT.
    - Goes to EMIT if ilast, else ACCUM.
  - ACCUM: each accepted element updates acc.
    - SUM: acc+idata.
    - MIN: smaller signed value.
    - MAX: larger signed value.
    - COUNT: acc+1.
    - op input ignored; latched op used.
    - Goes to EMIT if ilast.
  - EMIT: cvalid=1, cdata=acc.
    - If !cstop this cycle, the output buffer loads cdata; state goes to IDLE next cycle and cvalid drops.
    - If cstop, cdata/cvalid are held unchanged.
- Latency: element with ilast accepted at edge N; cvalid=1 with final result after edge N (visible cycle N+1).
- Throughput: group of K elements takes K+1 cycles minimum (one bubble per group for EMIT).
- cdata when cvalid=0: holds last emitted value; not to be relied on.
- COUNT saturates at 2^`NUM-1; never wraps negative.
- SUM overflow: per Optional Feature.
- ivalid=0 cycles inside a group: state and acc unchanged.
- Single-element group (ilast on first element): IDLE -> EMIT directly; result is idata (SUM/MIN/MAX) or 1 (COUNT).
- Reset mid-group or mid-EMIT: partial group discarded, cvalid drops immediately (async), no result emitted.
- cstop toggling during EMIT: result emitted exactly once, on first cycle with cstop=0.
- ivalid high while in EMIT: not accepted (istop=1); upstream holds it; it is accepted after return to IDLE.

Optional Feature:
- Macro AGG_SAT_EN.
- Defined: SUM saturates to +2^`NUM-1 on positive overflow and -2^`NUM on negative overflow. Saturation is sticky only via the value itself; later additions continue from the clamped value.
- Undefined: SUM wraps two's-complement modulo 2^(`NUM+1).
- COUNT saturation is present in both builds.

Test Plan (NUM=31):
- SUM group {5,-3,10} with ilast on 10, cstop=0 -> one cvalid pulse, cdata=12, cycle after ilast accept; istop high that cycle only.
- MIN {7,-2,4} then MAX {7,-2,4} back-to-back, ivalid held high -> cdata=-2 then 7. Exactly one istop bubble per group; op changes mid-group ignored.
- COUNT group of 6 elements with ivalid gaps, then cstop=1 for 3 cycles during EMIT -> cdata=6 held stable with cvalid=1 throughout; released once; istop=1 for 4 cycles.
- SUM {0x7FFFFFF0, 0x20} -> with AGG_SAT_EN cdata=0x7FFFFFFF; without, cdata=0x80000010.
- Single-element MAX {-9} -> cdata=-9 one cycle after accept.
- rst_n low after 2 elements of SUM group {1,2,...}, then new group {4} -> no result for partial group; cvalid=0 during reset; next result cdata=4.
